// File: rtl/dmem_access_ctrl_if.sv
// Data-bus interface between dmem_access_ctrl (master) and the data memory or
// interconnect (slave). Request/grant handshake plus a separate response phase
// that returns rvalid for both reads and writes.
interface dmem_access_ctrl_if;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [31:0] dbus_wdata_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_err_i;

  modport master (
    output dbus_req_o,
    output dbus_we_o,
    output dbus_addr_o,
    output dbus_wdata_o,
    output dbus_be_o,
    input  dbus_gnt_i,
    input  dbus_rvalid_i,
    input  dbus_rdata_i,
    input  dbus_err_i
  );

  modport slave (
    input  dbus_req_o,
    input  dbus_we_o,
    input  dbus_addr_o,
    input  dbus_wdata_o,
    input  dbus_be_o,
    output dbus_gnt_i,
    output dbus_rvalid_i,
    output dbus_rdata_i,
    output dbus_err_i
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Latches one load/store from the MEM
// stage, issues it on the data bus, stalls the pipeline until the response (or
// a timeout) and returns the raw read word to the LSU.
// Optional build macro DMEM_ACCESS_STATS_EN adds transaction/stall counters.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255  // must be >= 2
) (
  input  logic        clk,
  input  logic        arst_n,
  // MEM stage side
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  output logic        stall_o,
  output logic        mem_done_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_err_o,
`ifdef DMEM_ACCESS_STATS_EN
  output logic [31:0] stat_txn_o,
  output logic [31:0] stat_stall_o,
`endif
  // Data bus side
  dmem_access_ctrl_if.master dbus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value that still allows a response; reaching it without one times out.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;

  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_latch;
  logic            w_capture;
  logic [31:0]     w_cap_rdata;
  logic            w_cap_err;

  // Next-state, timeout counting and capture decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    w_cap_rdata = '0;
    w_cap_err   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mem_req_i) begin
          w_state_nxt = StReq;
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      StReq, StWait: begin
        // A response on the final allowed cycle still wins over the timeout.
        if (dbus.dbus_rvalid_i && (r_state == StWait || dbus.dbus_gnt_i)) begin
          w_state_nxt = StDone;
          w_capture   = 1'b1;
          w_cap_rdata = r_we ? 32'h0 : dbus.dbus_rdata_i;
          w_cap_err   = dbus.dbus_err_i;
        end else if (r_cnt == CntLast) begin
          w_state_nxt = StDone;
          w_capture   = 1'b1;
          w_cap_rdata = 32'h0;
          w_cap_err   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CntW'(1);
          if (r_state == StReq && dbus.dbus_gnt_i) begin
            w_state_nxt = StWait;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State register and timeout counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Request fields, sampled only when leaving IDLE so MEM-stage changes while busy are ignored.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_latch) begin
      r_we    <= mem_we_i;
      r_addr  <= mem_addr_i & 32'hFFFF_FFFC;
      r_wdata <= mem_wdata_i;
      r_be    <= mem_be_i;
    end
  end

  // Completion result, held until the next completion.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_rdata <= w_cap_rdata;
      r_err   <= w_cap_err;
    end
  end

  // Outputs decoded from registered state; stall in IDLE follows the incoming request.
  always_comb begin
    stall_o    = (r_state == StIdle) ? mem_req_i : (r_state != StDone);
    mem_done_o = (r_state == StDone);
  end

  assign mem_rdata_o       = r_rdata;
  assign mem_err_o         = r_err;
  assign dbus.dbus_req_o   = (r_state == StReq);
  assign dbus.dbus_we_o    = r_we;
  assign dbus.dbus_addr_o  = r_addr;
  assign dbus.dbus_wdata_o = r_wdata;
  assign dbus.dbus_be_o    = r_be;

`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] r_stat_txn;
  logic [31:0] r_stat_stall;

  // Free-running wrap-around counters of completions and stall cycles.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_stat_txn   <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_state == StDone) r_stat_txn <= r_stat_txn + 32'd1;
      if (stall_o)           r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_txn_o   = r_stat_txn;
  assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl. Each access is described by grant
// delay and response delay; expected timing and results are computed from those
// numbers and the timeout limit rather than from any state machine.
module tb_dmem_access_ctrl;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_wdata_i = '0;
  logic [3:0]  mem_be_i = '0;
  logic        stall_o;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;
`ifdef DMEM_ACCESS_STATS_EN
  logic [31:0] stat_txn_o;
  logic [31:0] stat_stall_o;
`endif

  dmem_access_ctrl_if dbus ();

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_be_i    (mem_be_i),
    .stall_o     (stall_o),
    .mem_done_o  (mem_done_o),
    .mem_rdata_o (mem_rdata_o),
    .mem_err_o   (mem_err_o),
`ifdef DMEM_ACCESS_STATS_EN
    .stat_txn_o  (stat_txn_o),
    .stat_stall_o(stat_stall_o),
`endif
    .dbus        (dbus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  // Reference model of held results and statistics.
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;
  int unsigned m_txn = 0;
  int unsigned m_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0;
    m_err   = 1'b0;
    m_txn   = 0;
    m_stall = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_done"}, mem_done_o, 0);
    chk({tag, "_rdata"}, mem_rdata_o, 0);
    chk({tag, "_err"}, mem_err_o, 0);
    chk({tag, "_req"}, dbus.dbus_req_o, 0);
    chk({tag, "_we"}, dbus.dbus_we_o, 0);
    chk({tag, "_addr"}, dbus.dbus_addr_o, 0);
    chk({tag, "_wdata"}, dbus.dbus_wdata_o, 0);
    chk({tag, "_be"}, dbus.dbus_be_o, 0);
  endtask

  // Idle cycles; with bus_noise the bus fires gnt+rvalid, which must be ignored.
  task automatic idle(input int n, input bit bus_noise, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      mem_req_i            = 1'b0;
      mem_we_i             = 1'($urandom);
      mem_addr_i           = $urandom;
      dbus.dbus_gnt_i      = bus_noise;
      dbus.dbus_rvalid_i   = bus_noise;
      dbus.dbus_rdata_i    = $urandom;
      dbus.dbus_err_i      = bus_noise;
      #1;
      chk({tag, "_done"}, mem_done_o, 0);
      chk({tag, "_stall"}, stall_o, 0);
      chk({tag, "_req"}, dbus.dbus_req_o, 0);
      chk({tag, "_rdata"}, mem_rdata_o, m_rdata);
      chk({tag, "_err"}, mem_err_o, m_err);
    end
  endtask

  // One access: grant after g request cycles, response d cycles after grant (0 = same cycle).
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int g, input int d,
                        input logic [31:0] rdata, input bit err, input string tag);
    int          r;
    int          done_n;
    int          req_last;
    logic [31:0] exp_rd;
    bit          exp_err;
    r = 1 + g + d;  // busy cycle index carrying the response
    if (r <= TO) begin
      done_n  = r + 1;
      exp_rd  = we ? 32'h0 : rdata;
      exp_err = err;
    end else begin
      done_n  = TO + 1;
      exp_rd  = 32'h0;
      exp_err = 1'b1;
    end
    req_last = (1 + g < TO) ? 1 + g : TO;
    for (int n = 0; n <= done_n; n++) begin
      @(posedge clk); #1;
      mem_req_i = 1'b1;
      if (n == 0) begin
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wdata;
        mem_be_i    = be;
      end else begin
        mem_we_i    = 1'($urandom);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_be_i    = 4'($urandom);
      end
      dbus.dbus_gnt_i    = (n == 1 + g) || (n > 1 + g && $urandom_range(1, 0) == 1);
      dbus.dbus_rvalid_i = (n == r) || (n < 1 + g && $urandom_range(1, 0) == 1);
      dbus.dbus_rdata_i  = (n == r) ? rdata : $urandom;
      dbus.dbus_err_i    = (n == r) ? err : 1'($urandom);
      #1;
      chk({tag, "_stall"}, stall_o, 32'(n < done_n));
      chk({tag, "_done"}, mem_done_o, 32'(n == done_n));
      chk({tag, "_req"}, dbus.dbus_req_o, 32'(n >= 1 && n <= req_last));
      if (n >= 1 && n <= req_last) begin
        chk({tag, "_addr"}, dbus.dbus_addr_o, addr & 32'hFFFF_FFFC);
        chk({tag, "_we"}, dbus.dbus_we_o, we);
        chk({tag, "_wdata"}, dbus.dbus_wdata_o, wdata);
        chk({tag, "_be"}, dbus.dbus_be_o, be);
      end
      chk({tag, "_rdata"}, mem_rdata_o, (n == done_n) ? exp_rd : m_rdata);
      chk({tag, "_err"}, mem_err_o, (n == done_n) ? 32'(exp_err) : 32'(m_err));
      if (n < done_n) m_stall++;
    end
    m_rdata = exp_rd;
    m_err   = exp_err;
    m_txn++;
  endtask

  initial begin
    dbus.dbus_gnt_i    = 1'b0;
    dbus.dbus_rvalid_i = 1'b0;
    dbus.dbus_rdata_i  = '0;
    dbus.dbus_err_i    = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
    @(posedge clk);
    @(posedge clk); #1;
    arst_n = 1'b1;
    model_reset();
    idle(2, 1'b1, "post_reset_idle");

    // Fastest load: same-cycle gnt+rvalid, unaligned address
    access(1'b0, 32'h0000_1003, 32'h0, 4'hF, 0, 0, 32'hDEAD_BEEF, 1'b0, "load_fast");
    // Store granted after 4 cycles, response 2 cycles later
    access(1'b1, 32'h0000_2008, 32'hABCD_0000, 4'b1100, 4, 2, 32'h5555_AAAA, 1'b0, "store");
    idle(1, 1'b0, "gap0");
    // Load with bus error, then a clean access clears it
    access(1'b0, 32'h0000_3004, 32'h0, 4'hF, 1, 1, 32'h1234_5678, 1'b1, "load_err");
    access(1'b0, 32'h0000_3010, 32'h0, 4'hF, 0, 2, 32'hCAFE_F00D, 1'b0, "load_clr");
    // No grant ever: timeout, then late responses ignored
    access(1'b0, 32'h0000_4000, 32'h0, 4'hF, 100, 0, 32'hFFFF_FFFF, 1'b0, "timeout");
    idle(3, 1'b1, "late_resp");
    // Response on the last allowed cycle, then one cycle too late
    access(1'b0, 32'h0000_5000, 32'h0, 4'hF, 3, 4, 32'h0BAD_CAFE, 1'b0, "edge_ok");
    access(1'b0, 32'h0000_5004, 32'h0, 4'hF, 3, 5, 32'h7777_7777, 1'b0, "edge_to");
    access(1'b0, 32'h0000_6000, 32'h0, 4'hF, 0, 0, 32'h8765_4321, 1'b0, "pre_rst");

    // Reset while in WAIT
    @(posedge clk); #1;
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h0000_7004;
    mem_wdata_i = 32'h1111_2222;
    mem_be_i    = 4'hF;
    dbus.dbus_gnt_i    = 1'b0;
    dbus.dbus_rvalid_i = 1'b0;
    #1;
    chk("rstw_idle_stall", stall_o, 1);
    @(posedge clk); #1;
    dbus.dbus_gnt_i = 1'b1;
    #1;
    chk("rstw_req", dbus.dbus_req_o, 1);
    @(posedge clk); #1;
    dbus.dbus_gnt_i = 1'b0;
    #1;
    chk("rstw_wait_req", dbus.dbus_req_o, 0);
    chk("rstw_wait_stall", stall_o, 1);
    mem_req_i = 1'b0;
    arst_n    = 1'b0;
    #1;
    chk_all_zero("rst_in_wait");
    model_reset();
    @(posedge clk); #1;
    arst_n = 1'b1;
    idle(3, 1'b1, "rstw_late_resp");
    access(1'b0, 32'h0000_7008, 32'h0, 4'hF, 1, 0, 32'h2468_ACE0, 1'b0, "after_rst");

`ifdef DMEM_ACCESS_STATS_EN
    // Counters restart at reset; three back-to-back single-cycle loads
    @(posedge clk); #1;
    mem_req_i = 1'b0;
    arst_n    = 1'b0;
    #1;
    chk("stat_rst_txn", stat_txn_o, 0);
    chk("stat_rst_stall", stat_stall_o, 0);
    model_reset();
    @(posedge clk); #1;
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, 0, 0, $urandom, 1'b0, "stat_load");
    end
    idle(1, 1'b0, "stat_gap");
    chk("stat_txn3", stat_txn_o, 3);
    chk("stat_stall6", stat_stall_o, 6);
`endif

    // Randomized accesses with occasional timeouts
    for (int i = 0; i < 24; i++) begin
      int g;
      int d;
      g = ($urandom_range(5, 0) == 0) ? 9 : int'($urandom_range(3, 0));
      d = int'($urandom_range(4, 0));
      access(1'($urandom), $urandom, $urandom, 4'($urandom), g, d, $urandom,
             ($urandom_range(3, 0) == 0), "rand");
      idle(int'($urandom_range(2, 0)), 1'($urandom), "rand_gap");
    end

    idle(1, 1'b0, "final_gap");
`ifdef DMEM_ACCESS_STATS_EN
    chk("stat_txn_final", stat_txn_o, m_txn);
    chk("stat_stall_final", stat_stall_o, m_stall);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences MEM-stage data-memory accesses onto a request/grant/response data bus with variable latency.
- Latches the MEM-stage request and holds the pipeline stalled until the response or a timeout.
- Returns raw read data to the LSU load path.
- Sits between the MEM stage (rd/opr_res/opr_b/dm_en/lsuop) and the external data memory or interconnect.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles spent in REQ+WAIT before forced error completion. Must be ≥2. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- mem_req_i  in  1  MEM stage holds a load or store (dm_en, or a load lsuop)
- mem_we_i  in  1  1 = store
- mem_addr_i  in  32  byte address (opr_res)
- mem_wdata_i  in  32  lane-aligned store data from LSU
- mem_be_i  in  4  byte enables from LSU
- stall_o  out  1  freeze IF..MEM stages
- mem_done_o  out  1  access complete this cycle
- mem_rdata_o  out  32  raw word to LSU (dmem_rdata)
- mem_err_o  out  1  bus error or timeout, valid with mem_done_o
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  bus write
- dbus_addr_o  out  32  word-aligned address, bits[1:0] = 0
- dbus_wdata_o  out  32  store data
- dbus_be_o  out  4  byte enables
- dbus_gnt_i  in  1  request accepted
- dbus_rvalid_i  in  1  response valid (reads and writes)
- dbus_rdata_i  in  32  read data
- dbus_err_i  in  1  error, qualified by dbus_rvalid_i

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. All dbus_* and mem_* outputs are registered or decoded from registered state only; there are no combinational bus-to-bus paths.
- Reset (async, arst_n=0):
  - state=IDLE, timeout counter=0.
  - All outputs 0: dbus_req_o drops in the same cycle as reset assertion.
  - An access in flight at reset is abandoned; late gnt/rvalid after reset are ignored in IDLE.
- IDLE:
  - mem_req_i=1 → latch we, {addr[31:2],2'b00}, wdata, be; go to REQ.
  - stall_o = mem_req_i.
- REQ:
  - dbus_req_o=1 with latched fields held stable until grant.
  - gnt & rvalid in same cycle → DONE, capture rdata/err.
  - gnt alone → WAIT.
- WAIT:
  - dbus_req_o=0.
  - rvalid → DONE, capture dbus_rdata_i (writes capture 0) and dbus_err_i.
- DONE:
  - mem_done_o=1, stall_o=0 for exactly one cycle; the pipeline advances.
  - Next state IDLE unconditionally.
- stall_o = mem_req_i in IDLE, 1 in REQ/WAIT, 0 in DONE.
- Latency: minimum 3 cycles from mem_req_i to mem_done_o (IDLE→REQ→DONE with same-cycle gnt+rvalid). Each access costs at least 2 stall cycles.
- mem_rdata_o / mem_err_o:
  - Hold their captured value until the next DONE; cleared only by reset.
  - Write completions set mem_rdata_o=0.
- Timeout:
  - Counter clears on IDLE→REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYCLES → DONE with mem_err_o=1, mem_rdata_o=0, dbus_req_o deasserted.
  - A response arriving afterwards is ignored.
- Ignored events:
  - rvalid in IDLE/REQ-without-gnt or DONE.
  - gnt outside REQ.
- Inputs mem_* are sampled only on IDLE→REQ. Changes while busy have no effect.

Optional Feature:
- Macro: DMEM_ACCESS_STATS_EN.
- Defined: adds output ports stat_txn_o[31:0] and stat_stall_o[31:0].
  - stat_txn_o increments on every DONE.
  - stat_stall_o increments every cycle stall_o=1.
  - Both wrap at 2^32, reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load, gnt+rvalid in REQ cycle, rdata=0xDEADBEEF, addr=0x1003 → dbus_addr_o=0x1000, mem_done_o at cycle 3, mem_rdata_o=0xDEADBEEF, stall_o high 2 cycles.
- Store be=4'b1100 wdata=0xABCD0000, gnt after 4 cycles, rvalid 2 cycles later → dbus fields stable during REQ, done with mem_rdata_o=0, mem_err_o=0.
- Load with dbus_err_i=1 on rvalid → mem_err_o=1 on done; next access clears it to 0.
- TIMEOUT_CYCLES=8, no gnt ever → dbus_req_o drops and mem_done_o=1 with mem_err_o=1 after 8 cycles in REQ; later rvalid ignored.
- arst_n pulsed low while in WAIT → all outputs 0 immediately; post-reset rvalid produces no mem_done_o; new request completes normally.
- With DMEM_ACCESS_STATS_EN, 3 back-to-back single-cycle-response loads → stat_txn_o=3, stat_stall_o=6.
